// File: rtl/subtree_rr_scheduler_if.sv
// Request/done/grant bundle between a subtree node's leaves and its round-robin scheduler.
// The slave side is the scheduler; the master side drives requests and completions.
interface subtree_rr_scheduler_if #(
  parameter int NUM_REQ = 5,
  parameter int CNT_W   = 8
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] done;
  logic               clr_flags;
  logic [NUM_REQ-1:0] gnt;
  logic               gnt_valid;
  logic [2:0]         gnt_id;
  logic               timeout_pulse;
  logic [2:0]         timeout_id;
  logic [NUM_REQ-1:0] timeout_flags;
  logic [CNT_W-1:0]   total_grants;

  modport master (
    output req, done, clr_flags,
    input  gnt, gnt_valid, gnt_id, timeout_pulse, timeout_id, timeout_flags, total_grants
  );

  modport slave (
    input  req, done, clr_flags,
    output gnt, gnt_valid, gnt_id, timeout_pulse, timeout_id, timeout_flags, total_grants
  );
endinterface

// File: rtl/subtree_rr_scheduler.sv
// Round-robin owner of one shared resource slot for the leaves under a subtree node.
// A grant is held until done or request drop; a watchdog forces release after MAX_HOLD cycles.
module subtree_rr_scheduler #(
  parameter int NUM_REQ  = 5,
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input logic                  clk,
  input logic                  rst,
  subtree_rr_scheduler_if.slave bus
);

  localparam int                HOLD_W    = $clog2(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  localparam logic [2:0]        LAST_RST  = 3'(NUM_REQ - 1);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_RELEASE} state_t;

  state_t             r_state,         w_state_nxt;
  logic [NUM_REQ-1:0] r_gnt,           w_gnt_nxt;
  logic               r_gnt_valid;
  logic [2:0]         r_gnt_id,        w_gnt_id_nxt;
  logic [2:0]         r_last_id,       w_last_id_nxt;
  logic [HOLD_W-1:0]  r_hold_cnt,      w_hold_cnt_nxt;
  logic               r_timeout_pulse, w_timeout_pulse_nxt;
  logic [2:0]         r_timeout_id,    w_timeout_id_nxt;
  logic [NUM_REQ-1:0] r_timeout_flags, w_timeout_flags_nxt;
  logic [CNT_W-1:0]   r_total_grants,  w_total_grants_nxt;

  logic               w_any_req;
  logic [2:0]         w_sel_id;
  logic [NUM_REQ-1:0] w_sel_onehot;
  logic               w_done_g;
  logic               w_req_g;
  logic               w_hold_max;
  logic               w_timeout;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  // Pick the requester closest above last_id; the leaf that just released sits at maximum distance.
  always_comb begin
    int best;
    int d;
    best      = NUM_REQ;
    d         = 0;
    w_sel_id  = r_last_id;
    w_any_req = |bus.req;
    for (int j = 0; j < NUM_REQ; j++) begin
      d = (j + 2 * NUM_REQ - int'(r_last_id) - 1) % NUM_REQ;
      if (bus.req[j] && (d < best)) begin
        best     = d;
        w_sel_id = 3'(j);
      end
    end
    w_sel_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_sel_id;
  end

  // r_gnt is one-hot, so masking with it selects the granted leaf's done/req bit.
  assign w_done_g   = |(bus.done & r_gnt);
  assign w_req_g    = |(bus.req & r_gnt);
  assign w_hold_max = (r_hold_cnt == HOLD_LAST);
  assign w_timeout  = w_hold_max & ~w_done_g;

  always_comb begin
    w_state_nxt         = r_state;
    w_gnt_nxt           = r_gnt;
    w_gnt_id_nxt        = r_gnt_id;
    w_last_id_nxt       = r_last_id;
    w_hold_cnt_nxt      = r_hold_cnt;
    w_timeout_pulse_nxt = 1'b0;
    w_timeout_id_nxt    = r_timeout_id;
    w_timeout_flags_nxt = bus.clr_flags ? '0 : r_timeout_flags;
    w_total_grants_nxt  = r_total_grants;
    case (r_state)
      S_IDLE, S_RELEASE: begin
        w_gnt_nxt = '0;
        if (w_any_req) begin
          w_state_nxt        = S_GRANT;
          w_gnt_nxt          = w_sel_onehot;
          w_gnt_id_nxt       = w_sel_id;
          w_last_id_nxt      = w_sel_id;
          w_hold_cnt_nxt     = '0;
          w_total_grants_nxt = sat_inc(r_total_grants);
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_GRANT: begin
        w_hold_cnt_nxt = r_hold_cnt + HOLD_W'(1);
        if (w_done_g || !w_req_g || w_hold_max) begin
          w_state_nxt = S_RELEASE;
          w_gnt_nxt   = '0;
          // A flag set in the same cycle as clr_flags survives.
          if (w_timeout) begin
            w_timeout_pulse_nxt = 1'b1;
            w_timeout_id_nxt    = r_gnt_id;
            w_timeout_flags_nxt = w_timeout_flags_nxt | r_gnt;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_gnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_gnt           <= '0;
      r_gnt_valid     <= 1'b0;
      r_gnt_id        <= '0;
      r_last_id       <= LAST_RST;
      r_hold_cnt      <= '0;
      r_timeout_pulse <= 1'b0;
      r_timeout_id    <= '0;
      r_timeout_flags <= '0;
      r_total_grants  <= '0;
    end else begin
      r_state         <= w_state_nxt;
      r_gnt           <= w_gnt_nxt;
      r_gnt_valid     <= |w_gnt_nxt;
      r_gnt_id        <= w_gnt_id_nxt;
      r_last_id       <= w_last_id_nxt;
      r_hold_cnt      <= w_hold_cnt_nxt;
      r_timeout_pulse <= w_timeout_pulse_nxt;
      r_timeout_id    <= w_timeout_id_nxt;
      r_timeout_flags <= w_timeout_flags_nxt;
      r_total_grants  <= w_total_grants_nxt;
    end
  end

  assign bus.gnt           = r_gnt;
  assign bus.gnt_valid     = r_gnt_valid;
  assign bus.gnt_id        = r_gnt_id;
  assign bus.timeout_pulse = r_timeout_pulse;
  assign bus.timeout_id    = r_timeout_id;
  assign bus.timeout_flags = r_timeout_flags;
  assign bus.total_grants  = r_total_grants;

endmodule
